// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divider.
// Holds the div_op encodings (funct3[1:0] of the M-extension divide group),
// which the decoder also uses, plus small helpers that classify an op.
package div_unit_pkg;

  localparam int DIV_OP_W = 2;

  typedef enum logic [DIV_OP_W-1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  // funct3[0] clear means the operands are two's complement.
  function automatic logic op_is_signed(input logic [DIV_OP_W-1:0] op);
    return ~op[0];
  endfunction

  // funct3[1] set selects the remainder instead of the quotient.
  function automatic logic op_is_rem(input logic [DIV_OP_W-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multicycle RV32M divider (DIV/DIVU/REM/REMU), restoring algorithm,
// one quotient bit per clock.
// Ports:
//   clk        - clock, all state on posedge
//   reset      - synchronous, active-high
//   div_valid  - request, sampled only while idle
//   div_op     - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend   - rs1, captured at accept
//   divisor    - rs2, captured at accept
//   div_ready  - one-cycle pulse, div_result valid this cycle
//   div_result - quotient or remainder, held until the next result load
//   div_busy   - high from the cycle after accept through the ready cycle
// Latency: accept at cycle 0 gives div_ready at cycle XLEN+2; divide-by-zero
// and signed overflow are resolved at accept and give div_ready at cycle 1.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                div_valid,
  input  logic [DIV_OP_W-1:0] div_op,
  input  logic [XLEN-1:0]     dividend,
  input  logic [XLEN-1:0]     divisor,
  output logic                div_ready,
  output logic [XLEN-1:0]     div_result,
  output logic                div_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state;
  logic [CNT_W-1:0]    count;
  logic [DIV_OP_W-1:0] op_q;
  logic [XLEN-1:0]     rem_q;
  logic [XLEN-1:0]     quot_q;   // holds the unconsumed dividend bits, then the quotient
  logic [XLEN-1:0]     dvsr_q;
  logic                neg_quot;
  logic                neg_rem;

  // Magnitude of a two's complement value; INT_MIN maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic            sgn_in;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    sgn_in   = op_is_signed(div_op);
    div_zero = (divisor == '0);
    div_ovf  = sgn_in && (dividend == INT_MIN) && (divisor == '1);
    special_res = '0;
    if (div_zero)
      special_res = op_is_rem(div_op) ? dividend : '1;
    else if (div_ovf)
      special_res = op_is_rem(div_op) ? '0 : INT_MIN;

    // One extra bit so the sign of the trial subtraction is exact even when
    // the shifted remainder reaches bit XLEN.
    rem_sh   = {rem_q, quot_q[XLEN-1]};
    trial    = rem_sh - {1'b0, dvsr_q};

    quot_fix = neg_if(quot_q, neg_quot);
    rem_fix  = neg_if(rem_q, neg_rem);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      op_q       <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      neg_quot   <= 1'b0;
      neg_rem    <= 1'b0;
      div_ready  <= 1'b0;
      div_busy   <= 1'b0;
      div_result <= '0;
    end else begin
      unique case (state)
        // Accept: capture operands as magnitudes plus result signs.
        S_IDLE: begin
          if (div_valid) begin
            op_q     <= div_op;
            quot_q   <= sgn_in ? abs_val(dividend) : dividend;
            dvsr_q   <= sgn_in ? abs_val(divisor) : divisor;
            neg_quot <= sgn_in & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_rem  <= sgn_in & dividend[XLEN-1];
            rem_q    <= '0;
            count    <= CNT_W'(XLEN - 1);
            div_busy <= 1'b1;
            if (div_zero || div_ovf) begin
              div_result <= special_res;
              div_ready  <= 1'b1;
              state      <= S_DONE;
            end else begin
              state      <= S_CALC;
            end
          end
        end
        // Iterate: one restoring step per clock.
        S_CALC: begin
          rem_q  <= trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], ~trial[XLEN]};
          count  <= count - CNT_W'(1);
          if (count == '0)
            state <= S_FIX;
        end
        // Sign fix-up and result select.
        S_FIX: begin
          div_result <= op_is_rem(op_q) ? rem_fix : quot_fix;
          div_ready  <= 1'b1;
          state      <= S_DONE;
        end
        // Ready cycle.
        S_DONE: begin
          div_ready <= 1'b0;
          div_busy  <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: table of requests with expected results and
// latencies; expected results go through a queue that a monitor drains on
// every div_ready pulse. Reset-abort is a separate hand-written sequence.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_valid;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_ready;
  logic [31:0] div_result;
  logic        div_busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int         LAT     = 34;
  localparam int         LAT_SP  = 1;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    bit          drop;
  } vec_t;

  vec_t vecs[$];

  div_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_valid  (div_valid),
    .div_op     (div_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_ready  (div_ready),
    .div_result (div_result),
    .div_busy   (div_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (div_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=0x%08h required=no_pulse", div_result);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("scoreboard_result", div_result, mon_exp);
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit drop);
    int n;
    @(negedge clk);
    chk({name, "_busy_before"}, {31'b0, div_busy}, 32'd0);
    div_valid = 1'b1;
    div_op    = op;
    dividend  = a;
    divisor   = b;
    exp_q.push_back(exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        dividend = $urandom;
        divisor  = $urandom;
        if (drop) div_valid = 1'b0;
      end
    end while (div_ready !== 1'b1 && n < 100);
    chk({name, "_latency"}, 32'(n), 32'(lat));
    if (div_ready !== 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
    chk({name, "_busy_at_ready"}, {31'b0, div_busy}, 32'd1);
    div_valid = 1'b0;
    @(negedge clk);
    chk({name, "_ready_width"}, {31'b0, div_ready}, 32'd0);
    chk({name, "_result_hold"}, div_result, exp);
    chk({name, "_busy_after"}, {31'b0, div_busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{"divu_100_7",     OP_DIVU, 32'd100,        32'd7,          32'd14,         LAT,    1'b0});
    vecs.push_back('{"div_m7_2",       OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   LAT,    1'b0});
    vecs.push_back('{"rem_m7_2",       OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   LAT,    1'b0});
    vecs.push_back('{"remu_fff9_2",    OP_REMU, 32'hFFFFFFF9,   32'd2,          32'd1,          LAT,    1'b1});
    vecs.push_back('{"div_5_0",        OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   LAT_SP, 1'b0});
    vecs.push_back('{"remu_5_0",       OP_REMU, 32'd5,          32'd0,          32'd5,          LAT_SP, 1'b0});
    vecs.push_back('{"divu_5_0",       OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   LAT_SP, 1'b0});
    vecs.push_back('{"rem_m5_0",       OP_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   LAT_SP, 1'b0});
    vecs.push_back('{"div_ovf",        OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   LAT_SP, 1'b0});
    vecs.push_back('{"rem_ovf",        OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          LAT_SP, 1'b1});
    vecs.push_back('{"div_1000_m10",   OP_DIV,  32'd1000,       32'hFFFFFFF6,   32'hFFFFFF9C,   LAT,    1'b0});
    vecs.push_back('{"divu_max_1",     OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   LAT,    1'b0});
    vecs.push_back('{"remu_min_3",     OP_REMU, 32'h80000000,   32'd3,          32'd2,          LAT,    1'b0});
    vecs.push_back('{"div_min_2",      OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   LAT,    1'b0});
    vecs.push_back('{"div_7_m3",       OP_DIV,  32'd7,          32'hFFFFFFFD,   32'hFFFFFFFE,   LAT,    1'b0});
    vecs.push_back('{"rem_7_m3",       OP_REM,  32'd7,          32'hFFFFFFFD,   32'd1,          LAT,    1'b0});
    vecs.push_back('{"divu_3_min",     OP_DIVU, 32'd3,          32'h80000000,   32'd0,          LAT,    1'b0});
    vecs.push_back('{"remu_max_min",   OP_REMU, 32'hFFFFFFFF,   32'h80000000,   32'h7FFFFFFF,   LAT,    1'b0});
    vecs.push_back('{"divu_max_max",   OP_DIVU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          LAT,    1'b0});
    vecs.push_back('{"div_m1_m1",      OP_DIV,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          LAT,    1'b0});

    reset     = 1'b1;
    div_valid = 1'b0;
    div_op    = 2'b00;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",  {31'b0, div_ready}, 32'd0);
    chk("reset_busy",   {31'b0, div_busy},  32'd0);
    chk("reset_result", div_result,         32'd0);
    reset = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].drop);

    // Reset during cycle 10 of DIVU 100/7: no pulse, outputs cleared.
    @(negedge clk);
    div_valid = 1'b1;
    div_op    = OP_DIVU;
    dividend  = 32'd100;
    divisor   = 32'd7;
    repeat (10) @(negedge clk);
    reset     = 1'b1;
    div_valid = 1'b0;
    @(negedge clk);
    chk("abort_ready",  {31'b0, div_ready}, 32'd0);
    chk("abort_busy",   {31'b0, div_busy},  32'd0);
    chk("abort_result", div_result,         32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_busy_later", {31'b0, div_busy}, 32'd0);
    run_op("divu_9_3_after_abort", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
